// File: rtl/riscv_defines.sv
// Shared TPR field constants and the update sequencer state type.
// Imported by the TPR update controller and its in-flight counter.
package riscv_defines;

  localparam int TPR_MODE_LOW  = 0;
  localparam int TPR_MODE_HIGH = 3;
  localparam int TPR_TAG_LOW   = 4;
  localparam int TPR_TAG_HIGH  = 30;
  localparam int TPR_LOCK_BIT  = 31;

  typedef enum logic [1:0] {
    TPR_IDLE,
    TPR_DRAIN,
    TPR_COMMIT
  } tpr_ctrl_state_e;

endpackage

// File: rtl/riscv_inflight_counter.sv
// Counts instructions between ID issue and WB retire.
// Flush clears it; saturation and underflow are held and asserted.
module riscv_inflight_counter
  import riscv_defines::*;
#(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         issue_i,
  input  logic         retire_i,
  input  logic         flush_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  localparam logic [W-1:0] CMAX = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: flush wins, then issue-only / retire-only.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (issue_i && !retire_i) begin
      if (count_q != CMAX) count_d = count_q + W'(1);
    end else if (retire_i && !issue_i) begin
      if (count_q != '0) count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

  a_no_sat: assert property (@(posedge clk)
    disable iff (!rst_n)
    !(issue_i && !retire_i && !flush_i
      && count_q == CMAX));

  a_no_under: assert property (@(posedge clk)
    disable iff (!rst_n)
    !(retire_i && !issue_i && !flush_i
      && count_q == '0));

endmodule

// File: rtl/riscv_tpr_update_ctrl.sv
// TPR update sequencer: drains tagged in-flight work, then commits.
// Optional LOCK bit behaviour enabled with DIFT_TPR_LOCK_EN.
module riscv_tpr_update_ctrl
  import riscv_defines::*;
#(
  parameter logic [31:0] TPR_RESET     = 32'h0000_0000,
  parameter int          MAX_INFLIGHT  = 4,
  parameter int          DRAIN_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_tpr_we_i,
  input  logic [31:0] csr_tpr_wdata_i,
  output logic        csr_tpr_ready_o,
  input  logic        issue_i,
  input  logic        retire_i,
  input  logic        flush_i,
  output logic        stall_id_o,
  output logic [31:0] tpr_o,
  output logic        tpr_pending_o,
`ifdef DIFT_TPR_LOCK_EN
  output logic        tpr_lock_err_o,
`endif
  output logic        drain_timeout_o
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST =
    TW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);

  tpr_ctrl_state_e state_q, state_d;
  logic [31:0]     tpr_q, tpr_d;
  logic [31:0]     pend_q, pend_d;
  logic [TW-1:0]   to_q, to_d;

  logic [CW-1:0] inflight;
  logic          inflight_zero;
  logic          locked;
  logic          lock_err;
  logic          timeout;

  riscv_inflight_counter #(
    .MAX (MAX_INFLIGHT)
  ) u_inflight (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue_i  (issue_i),
    .retire_i (retire_i),
    .flush_i  (flush_i),
    .count_o  (inflight),
    .zero_o   (inflight_zero)
  );

`ifdef DIFT_TPR_LOCK_EN
  assign locked = tpr_q[TPR_LOCK_BIT];
`else
  assign locked = 1'b0;
`endif

  // Next-state, commit datapath and handshake outputs.
  always_comb begin
    state_d         = state_q;
    tpr_d           = tpr_q;
    pend_d          = pend_q;
    to_d            = to_q;
    csr_tpr_ready_o = 1'b0;
    stall_id_o      = 1'b1;
    timeout         = 1'b0;
    lock_err        = 1'b0;
    unique case (state_q)
      TPR_IDLE: begin
        csr_tpr_ready_o = 1'b1;
        stall_id_o      = csr_tpr_we_i && !locked;
        lock_err        = csr_tpr_we_i && locked;
        if (csr_tpr_we_i && !locked) begin
          pend_d  = csr_tpr_wdata_i;
          to_d    = '0;
          state_d = TPR_DRAIN;
        end
      end
      TPR_DRAIN: begin
        to_d = to_q + TW'(1);
        if (inflight_zero) begin
          tpr_d   = pend_q;
          state_d = TPR_COMMIT;
        end else if (to_q == TO_LAST) begin
          tpr_d   = pend_q;
          timeout = 1'b1;
          state_d = TPR_COMMIT;
        end
      end
      TPR_COMMIT: begin
        state_d = TPR_IDLE;
      end
      default: begin
        state_d = TPR_IDLE;
      end
    endcase
  end

  // State and TPR registers; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TPR_IDLE;
      tpr_q   <= TPR_RESET;
      pend_q  <= TPR_RESET;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      tpr_q   <= tpr_d;
      pend_q  <= pend_d;
      to_q    <= to_d;
    end
  end

  assign tpr_o           = tpr_q;
  assign tpr_pending_o   = (state_q == TPR_DRAIN);
  assign drain_timeout_o = timeout && rst_n;
`ifdef DIFT_TPR_LOCK_EN
  assign tpr_lock_err_o  = lock_err && rst_n;
`endif

  a_inflight_range: assert property (@(posedge clk)
    disable iff (!rst_n)
    inflight <= CMAX);

endmodule

// File: tb/tb_riscv_tpr_update_ctrl.sv
// Self-checking bench for riscv_tpr_update_ctrl.
// Vector table, corner sequences, and a randomized model check.
module tb_riscv_tpr_update_ctrl;

  localparam logic [31:0] RST_V = 32'h0000_00A5;
  localparam int MAXI = 4;
  localparam int DT   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [31:0] wd;
  logic        rdy;
  logic        iss, ret, fl;
  logic        stl;
  logic [31:0] tpr;
  logic        pnd;
  logic        tmo;
`ifdef DIFT_TPR_LOCK_EN
  logic        lerr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_tpr_update_ctrl #(
    .TPR_RESET     (RST_V),
    .MAX_INFLIGHT  (MAXI),
    .DRAIN_TIMEOUT (DT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_tpr_we_i    (we),
    .csr_tpr_wdata_i (wd),
    .csr_tpr_ready_o (rdy),
    .issue_i         (iss),
    .retire_i        (ret),
    .flush_i         (fl),
    .stall_id_o      (stl),
    .tpr_o           (tpr),
    .tpr_pending_o   (pnd),
`ifdef DIFT_TPR_LOCK_EN
    .tpr_lock_err_o  (lerr),
`endif
    .drain_timeout_o (tmo)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] wd;
    logic        iss;
    logic        ret;
    logic        fl;
    logic        rdy;
    logic        stl;
    logic        pnd;
    logic        to;
    logic [31:0] tpr;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(
    input logic r, input logic w,
    input logic [31:0] d, input logic i,
    input logic t, input logic f,
    input logic er, input logic es,
    input logic ep, input logic eo,
    input logic [31:0] et);
    vec_t v;
    v.rst = r; v.we = w; v.wd = d;
    v.iss = i; v.ret = t; v.fl = f;
    v.rdy = er; v.stl = es; v.pnd = ep;
    v.to = eo; v.tpr = et;
    return v;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               n, a, e);
    end
  endtask

  task automatic chk_all(input string n,
    input logic er, input logic es,
    input logic ep, input logic eo,
    input logic [31:0] et);
    chk({n, ".ready"},   32'(rdy), 32'(er));
    chk({n, ".stall"},   32'(stl), 32'(es));
    chk({n, ".pending"}, 32'(pnd), 32'(ep));
    chk({n, ".timeout"}, 32'(tmo), 32'(eo));
    chk({n, ".tpr"},     tpr, et);
  endtask

  task automatic drv(input logic w,
    input logic [31:0] d, input logic i,
    input logic t, input logic f);
    rst_n = 1'b1;
    we = w; wd = d; iss = i; ret = t; fl = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // behavioural model state
  logic [31:0] m_tpr, m_val;
  bit          m_pend, m_post;
  int          m_wait, m_inf;

  initial begin
    logic e_stl, e_to, n_post, m_idle;
    string nm;

    tbl[0]  = mk(1,1,32'h1234,0,0,0, 1,1,0,0,RST_V);
    tbl[1]  = mk(1,0,0,0,0,0,        0,1,1,0,RST_V);
    tbl[2]  = mk(1,0,0,0,0,0,        0,1,0,0,32'h1234);
    tbl[3]  = mk(1,0,0,0,0,0,        1,0,0,0,32'h1234);
    tbl[4]  = mk(1,0,0,1,0,0,        1,0,0,0,32'h1234);
    tbl[5]  = mk(1,0,0,1,0,0,        1,0,0,0,32'h1234);
    tbl[6]  = mk(1,1,32'h5678,0,0,0, 1,1,0,0,32'h1234);
    tbl[7]  = mk(1,1,32'hFFFF,0,0,0, 0,1,1,0,32'h1234);
    tbl[8]  = mk(1,1,32'hFFFF,0,1,0, 0,1,1,0,32'h1234);
    tbl[9]  = mk(1,0,0,0,1,0,        0,1,1,0,32'h1234);
    tbl[10] = mk(1,0,0,0,0,0,        0,1,1,0,32'h1234);
    tbl[11] = mk(1,0,0,0,0,0,        0,1,0,0,32'h5678);
    tbl[12] = mk(1,0,0,0,0,0,        1,0,0,0,32'h5678);
    tbl[13] = mk(1,0,0,1,0,0,        1,0,0,0,32'h5678);
    tbl[14] = mk(1,1,32'h9999,0,0,0, 1,1,0,0,32'h5678);
    tbl[15] = mk(1,0,0,0,0,0,        0,1,1,0,32'h5678);
    tbl[16] = mk(0,0,0,0,0,0,        0,1,1,0,32'h5678);
    tbl[17] = mk(1,0,0,0,0,0,        1,0,0,0,RST_V);
    tbl[18] = mk(1,1,32'h42,0,0,0,   1,1,0,0,RST_V);
    tbl[19] = mk(1,0,0,0,0,0,        0,1,1,0,RST_V);
    tbl[20] = mk(1,0,0,0,0,0,        0,1,0,0,32'h42);
    tbl[21] = mk(1,0,0,0,0,0,        1,0,0,0,32'h42);

    do_reset();
    drv(0, 0, 0, 0, 0);
    #1;
    chk_all("reset", 1, 0, 0, 0, RST_V);
    step();

    for (int k = 0; k < 22; k++) begin
      drv(tbl[k].we, tbl[k].wd, tbl[k].iss,
          tbl[k].ret, tbl[k].fl);
      rst_n = tbl[k].rst;
      #1;
      nm = $sformatf("vec%0d", k);
      chk_all(nm, tbl[k].rdy, tbl[k].stl,
              tbl[k].pnd, tbl[k].to, tbl[k].tpr);
      step();
    end

    // three in flight, retires let the count reach 0 at t+5
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 1, 0, 0); step();
    end
    drv(1, 32'hABCD_0001, 0, 0, 0); #1;
    chk_all("h1.t0", 1, 1, 0, 0, 32'h42); step();
    drv(0, 0, 0, 1, 0); step();
    drv(0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 1, 0); step();
    drv(0, 0, 0, 1, 0); #1;
    chk_all("h1.t4", 0, 1, 1, 0, 32'h42); step();
    drv(0, 0, 0, 0, 0); #1;
    chk_all("h1.t5", 0, 1, 1, 0, 32'h42); step();
    chk_all("h1.t6", 0, 1, 0, 0, 32'hABCD_0001);
    step();
    chk_all("h1.t7", 1, 0, 0, 0, 32'hABCD_0001);
    step();

    // two in flight and no retires: forced commit
    for (int k = 0; k < 2; k++) begin
      drv(0, 0, 1, 0, 0); step();
    end
    drv(1, 32'h2222, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      #1;
      nm = $sformatf("h2.t%0d", k);
      chk_all(nm, 0, 1, 1, 0, 32'hABCD_0001);
      step();
    end
    chk_all("h2.t8", 0, 1, 1, 1, 32'hABCD_0001);
    step();
    chk_all("h2.t9", 0, 1, 0, 0, 32'h2222);
    step();
    chk_all("h2.t10", 1, 0, 0, 0, 32'h2222);
    drv(0, 0, 0, 1, 0); step();
    drv(0, 0, 0, 1, 0); step();

    // flush during DRAIN with three in flight
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 1, 0, 0); step();
    end
    drv(1, 32'h3333, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0); #1;
    chk_all("h3.t1", 0, 1, 1, 0, 32'h2222); step();
    drv(0, 0, 0, 0, 1); #1;
    chk_all("h3.t2", 0, 1, 1, 0, 32'h2222); step();
    drv(0, 0, 0, 0, 0); #1;
    chk_all("h3.t3", 0, 1, 1, 0, 32'h2222); step();
    chk_all("h3.t4", 0, 1, 0, 0, 32'h3333); step();
    chk_all("h3.t5", 1, 0, 0, 0, 32'h3333); step();

    // randomized run against the model
    do_reset();
    m_tpr = RST_V; m_val = RST_V;
    m_pend = 0; m_post = 0; m_wait = 0; m_inf = 0;
    for (int c = 0; c < 600; c++) begin
      drv(($urandom % 6) == 0, $urandom, 0, 0, 0);
`ifdef DIFT_TPR_LOCK_EN
      wd[31] = 1'b0;
`endif
      m_idle = !m_pend && !m_post;
      e_stl  = !m_idle || (m_idle && we);
      e_to   = m_pend && m_inf != 0
               && m_wait == DT - 1;
      iss = (m_inf < MAXI) && !e_stl
            && (($urandom % 3) == 0);
      ret = (m_inf > 0) && (($urandom % 3) == 0);
      fl  = ($urandom % 25) == 0;
      #1;
      nm = $sformatf("rnd%0d", c);
      chk_all(nm, m_idle, e_stl, m_pend, e_to, m_tpr);
      n_post = 0;
      if (m_pend) begin
        if (m_inf == 0 || m_wait == DT - 1) begin
          m_tpr  = m_val;
          m_pend = 0;
          n_post = 1;
        end else begin
          m_wait++;
        end
      end else if (!m_post && we) begin
        m_val  = wd;
        m_pend = 1;
        m_wait = 0;
      end
      m_post = n_post;
      if (fl) m_inf = 0;
      else if (iss && !ret) m_inf++;
      else if (ret && !iss) m_inf--;
      step();
    end

`ifdef DIFT_TPR_LOCK_EN
    do_reset();
    drv(1, 32'h8000_0005, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0); step();
    step();
    chk_all("lk.idle", 1, 0, 0, 0, 32'h8000_0005);
    drv(1, 32'h0, 0, 0, 0); #1;
    chk_all("lk.wr", 1, 0, 0, 0, 32'h8000_0005);
    chk("lk.err", 32'(lerr), 32'd1);
    step();
    drv(0, 0, 0, 0, 0); #1;
    chk_all("lk.after", 1, 0, 0, 0, 32'h8000_0005);
    chk("lk.err_off", 32'(lerr), 32'd0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
